// File: rtl/hdmi_tmds_pkg.sv
// Shared constants and helpers for the TMDS/TERC4 encoder array.
//   - MODE_* : encoding mode codes carried on the shared mode bus.
//   - CTRL_SYM_* : the four TMDS control-period symbols.
//   - Video-guard and island-guard symbol constants.
//   - terc4_encode() : TERC4 nibble-to-symbol table.
//   - ctrl_symbol() : control_data-to-symbol table.
//   - lane_to_cn() : maps a physical lane index to its HDMI channel number.
//   - mode_is_legal() : true for mode codes 0..4.
// Symbols are written as q_out[9:0]; bit 0 is transmitted first.
package hdmi_tmds_pkg;

    localparam logic [2:0] MODE_CTRL         = 3'd0;
    localparam logic [2:0] MODE_VIDEO        = 3'd1;
    localparam logic [2:0] MODE_VIDEO_GUARD  = 3'd2;
    localparam logic [2:0] MODE_ISLAND       = 3'd3;
    localparam logic [2:0] MODE_ISLAND_GUARD = 3'd4;

    localparam logic [9:0] CTRL_SYM_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_SYM_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_SYM_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_SYM_11 = 10'b1010101011;

    localparam logic [9:0] VIDEO_GUARD_CN02  = 10'b1011001100;
    localparam logic [9:0] VIDEO_GUARD_CN1   = 10'b0100110011;
    localparam logic [9:0] ISLAND_GUARD_CN12 = 10'b0100110011;

    function automatic logic [9:0] ctrl_symbol(input logic [1:0] cd);
        logic [9:0] sym;
        case (cd)
            2'b00:   sym = CTRL_SYM_00;
            2'b01:   sym = CTRL_SYM_01;
            2'b10:   sym = CTRL_SYM_10;
            default: sym = CTRL_SYM_11;
        endcase
        return sym;
    endfunction

    function automatic logic [9:0] terc4_encode(input logic [3:0] nib);
        logic [9:0] sym;
        case (nib)
            4'b0000: sym = 10'b1010011100;
            4'b0001: sym = 10'b1001100011;
            4'b0010: sym = 10'b1011100100;
            4'b0011: sym = 10'b1011100010;
            4'b0100: sym = 10'b0101110001;
            4'b0101: sym = 10'b0100011110;
            4'b0110: sym = 10'b0110001110;
            4'b0111: sym = 10'b0100111100;
            4'b1000: sym = 10'b1011001100;
            4'b1001: sym = 10'b0100111001;
            4'b1010: sym = 10'b0110011100;
            4'b1011: sym = 10'b1011000110;
            4'b1100: sym = 10'b1010001110;
            4'b1101: sym = 10'b1001110001;
            4'b1110: sym = 10'b0101100011;
            default: sym = 10'b1011000011;
        endcase
        return sym;
    endfunction

    function automatic int unsigned lane_to_cn(input int unsigned lane);
        return lane % 3;
    endfunction

    function automatic logic mode_is_legal(input logic [2:0] m);
        return (m <= MODE_ISLAND_GUARD);
    endfunction

endpackage

// File: rtl/tmds_encoder_array_if.sv
// Bus bundle between the frame/packet sequencer and the encoder array.
//   mode             : shared encoding mode (sequencer -> encoder)
//   video_data       : 8 bits per lane
//   data_island_data : 4 bits per lane (TERC4 nibble)
//   control_data     : 2 bits per lane
//   tmds             : 10-bit symbol per lane (encoder -> serialisers)
//   disparity        : 5-bit signed running disparity per lane
//   mode_error       : sticky illegal-mode flag
// master = sequencer side, slave = encoder side.
interface tmds_encoder_array_if #(
    parameter int NUM_CHANNELS = 3
);
    logic [2:0]                  mode;
    logic [8*NUM_CHANNELS-1:0]   video_data;
    logic [4*NUM_CHANNELS-1:0]   data_island_data;
    logic [2*NUM_CHANNELS-1:0]   control_data;
    logic [10*NUM_CHANNELS-1:0]  tmds;
    logic [5*NUM_CHANNELS-1:0]   disparity;
    logic                        mode_error;

    modport master (
        output mode, video_data, data_island_data, control_data,
        input  tmds, disparity, mode_error
    );

    modport slave (
        input  mode, video_data, data_island_data, control_data,
        output tmds, disparity, mode_error
    );
endinterface

// File: rtl/tmds_lane_pipe.sv
// One TMDS lane: two pipeline stages plus the running-disparity accumulator.
//   Stage 1 registers q_m (transition-minimised byte), N1(q_m[7:0]), the
//   TERC4 nibble and control_data. Stage 2 selects the output symbol for the
//   stage-1 mode (supplied by the top level) and updates the accumulator.
// Ports:
//   clk_pixel, reset : pixel clock, synchronous active-high reset
//   mode_s1          : mode already registered by the top (aligned to stage 1)
//   video_data, island_data, control_data : this lane's raw inputs
//   tmds             : registered output symbol
//   disparity        : accumulator value matching the symbol on tmds
module tmds_lane_pipe
    import hdmi_tmds_pkg::*;
#(
    parameter int unsigned LANE               = 0,
    parameter bit          RESET_ACC_ON_BLANK = 1'b1
) (
    input  logic              clk_pixel,
    input  logic              reset,
    input  logic [2:0]        mode_s1,
    input  logic [7:0]        video_data,
    input  logic [3:0]        island_data,
    input  logic [1:0]        control_data,
    output logic [9:0]        tmds,
    output logic signed [4:0] disparity
);

    localparam int unsigned CN = lane_to_cn(LANE);

    // ---------------- stage 1 ----------------
    logic [8:0] q_m_q, q_m_d;
    logic [3:0] n1_q, n1_d;
    logic [3:0] nib_q, nib_d;
    logic [1:0] ctl_q, ctl_d;
    logic [3:0] n1_data;
    logic       use_xnor;

    always_comb begin
        n1_data = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1_data = n1_data + 4'(video_data[i]);
        end
        // XNOR chain minimises transitions for bytes with many ones.
        use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !video_data[0]);
        q_m_d    = 9'd0;
        q_m_d[0] = video_data[0];
        for (int i = 1; i < 8; i++) begin
            q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ video_data[i])
                                :  (q_m_d[i-1] ^ video_data[i]);
        end
        q_m_d[8] = ~use_xnor;
        n1_d = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1_d = n1_d + 4'(q_m_d[i]);
        end
        nib_d = island_data;
        ctl_d = control_data;
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            q_m_q <= 9'd0;
            n1_q  <= 4'd0;
            nib_q <= 4'd0;
            ctl_q <= 2'b00;
        end else begin
            q_m_q <= q_m_d;
            n1_q  <= n1_d;
            nib_q <= nib_d;
            ctl_q <= ctl_d;
        end
    end

    // ---------------- stage 2 ----------------
    logic [9:0]        tmds_q, tmds_d;
    logic signed [4:0] acc_q, acc_d;
    logic signed [4:0] n1s, n0s, diff;

    always_comb begin
        tmds_d = CTRL_SYM_00;
        acc_d  = RESET_ACC_ON_BLANK ? 5'sd0 : acc_q;
        n1s    = signed'({1'b0, n1_q});
        n0s    = 5'sd8 - n1s;
        diff   = n1s - n0s;
        case (mode_s1)
            MODE_CTRL: tmds_d = ctrl_symbol(ctl_q);
            MODE_VIDEO: begin
                if ((acc_q == 5'sd0) || (n1s == n0s)) begin
                    // No bias to correct: bit 9 simply flags XNOR encoding.
                    tmds_d = {~q_m_q[8], q_m_q[8],
                              q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
                    acc_d  = q_m_q[8] ? (acc_q + diff) : (acc_q - diff);
                end else if ((!acc_q[4] && (n1s > n0s)) || (acc_q[4] && (n0s > n1s))) begin
                    // Byte would push disparity further the same way: invert it.
                    tmds_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
                    acc_d  = acc_q + signed'({3'b000, q_m_q[8], 1'b0}) - diff;
                end else begin
                    tmds_d = {1'b0, q_m_q[8], q_m_q[7:0]};
                    acc_d  = acc_q - signed'({3'b000, ~q_m_q[8], 1'b0}) + diff;
                end
            end
            MODE_VIDEO_GUARD:  tmds_d = (CN == 1) ? VIDEO_GUARD_CN1 : VIDEO_GUARD_CN02;
            MODE_ISLAND:       tmds_d = terc4_encode(nib_q);
            // Channel 0 keeps carrying HSYNC/VSYNC inside the island guard band.
            MODE_ISLAND_GUARD: tmds_d = (CN == 0) ? terc4_encode({2'b11, ctl_q})
                                                  : ISLAND_GUARD_CN12;
            default:           tmds_d = CTRL_SYM_00;
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            tmds_q <= CTRL_SYM_00;
            acc_q  <= 5'sd0;
        end else begin
            tmds_q <= tmds_d;
            acc_q  <= acc_d;
        end
    end

    assign tmds      = tmds_q;
    assign disparity = acc_q;

endmodule

// File: rtl/tmds_encoder_array.sv
// Multi-lane TMDS/TERC4 encoder with fixed 2-cycle latency in every mode.
// The top holds the shared stage-1 mode register, the sticky mode_error flag
// and the per-lane bus slicing; each lane is a tmds_lane_pipe instance.
// Ports:
//   clk_pixel : pixel clock
//   reset     : synchronous active-high reset
//   bus       : slave side of tmds_encoder_array_if (inputs, symbols,
//               disparity, mode_error)
module tmds_encoder_array
    import hdmi_tmds_pkg::*;
#(
    parameter int NUM_CHANNELS       = 3,
    parameter bit RESET_ACC_ON_BLANK = 1'b1
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    tmds_encoder_array_if.slave   bus
);

    logic [2:0] mode_s1_q, mode_s1_d;
    logic       mode_error_q, mode_error_d;

    logic [10*NUM_CHANNELS-1:0] tmds_all;
    logic [5*NUM_CHANNELS-1:0]  disp_all;

    // mode_error is evaluated from the stage-1 mode so it rises on the same
    // edge that loads the substitute control symbol into the lanes.
    always_comb begin
        mode_s1_d    = bus.mode;
        mode_error_d = mode_error_q | ~mode_is_legal(mode_s1_q);
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            mode_s1_q    <= MODE_CTRL;
            mode_error_q <= 1'b0;
        end else begin
            mode_s1_q    <= mode_s1_d;
            mode_error_q <= mode_error_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_lane
            tmds_lane_pipe #(
                .LANE               (gi),
                .RESET_ACC_ON_BLANK (RESET_ACC_ON_BLANK)
            ) u_lane (
                .clk_pixel    (clk_pixel),
                .reset        (reset),
                .mode_s1      (mode_s1_q),
                .video_data   (bus.video_data[8*gi +: 8]),
                .island_data  (bus.data_island_data[4*gi +: 4]),
                .control_data (bus.control_data[2*gi +: 2]),
                .tmds         (tmds_all[10*gi +: 10]),
                .disparity    (disp_all[5*gi +: 5])
            );
        end
    endgenerate

    assign bus.tmds       = tmds_all;
    assign bus.disparity  = disp_all;
    assign bus.mode_error = mode_error_q;

endmodule
